// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: synchronised inputs, debounced buttons with
// sticky press events and maskable interrupt, output port with atomic set/clear.
module gpio_ctrl #(
    parameter logic [7:0]  BASE_ADDR       = 8'h05,
    parameter int unsigned IN_WIDTH        = 32,
    parameter int unsigned OUT_WIDTH       = 32,
    parameter int unsigned BTN_COUNT       = 3,
    parameter int unsigned SW_COUNT        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    input  logic [BTN_COUNT-1:0] button,
    input  logic [SW_COUNT-1:0]  switch,
    inout  wire  [63:0]          data,
    input  logic [63:0]          address,
    input  logic                 read,
    input  logic                 write,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);

    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SW_LSB  = IN_WIDTH;
    localparam int unsigned BTN_LSB = IN_WIDTH + SW_COUNT;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [55:0] OFF_IN    = 56'd0;
    localparam logic [55:0] OFF_OUT   = 56'd1;
    localparam logic [55:0] OFF_SET   = 56'd2;
    localparam logic [55:0] OFF_CLR   = 56'd3;
    localparam logic [55:0] OFF_EVENT = 56'd4;
    localparam logic [55:0] OFF_MASK  = 56'd5;

    // Two-flop synchronisers
    logic [IN_WIDTH-1:0]  in_s1, in_sync;
    logic [SW_COUNT-1:0]  sw_s1, sw_sync;
    logic [BTN_COUNT-1:0] btn_s1, btn_sync;

    // Debounce state
    logic [BTN_COUNT-1:0]            btn_db, btn_db_next;
    logic [BTN_COUNT-1:0][CNT_W-1:0] cnt, cnt_next;
    logic [BTN_COUNT-1:0]            press;

    // Programmer-visible registers
    logic [BTN_COUNT-1:0] evt, evt_next;
    logic [BTN_COUNT-1:0] mask, mask_next;
    logic [OUT_WIDTH-1:0] out_next;
    logic                 irq_next;

    // Bus decode
    logic        selected;
    logic        wr_en;
    logic [55:0] offset;
    logic [63:0] rdata;
    logic        unused_data;

    assign selected    = (address[63:56] == BASE_ADDR);
    assign offset      = address[55:0];
    assign wr_en       = write & selected;
    assign unused_data = ^data;

    // Bus is driven only for a selected read; pre-edge values are returned
    assign data = (read && selected) ? rdata : 64'bz;

    // Read mux; unmapped and write-only offsets return zero
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_IN: begin
                rdata[IN_WIDTH-1:0]           = in_sync;
                rdata[SW_LSB +: SW_COUNT]     = sw_sync;
                rdata[BTN_LSB +: BTN_COUNT]   = btn_db;
            end
            OFF_OUT:   rdata[OUT_WIDTH-1:0] = gpio_out;
            OFF_EVENT: rdata[BTN_COUNT-1:0] = evt;
            OFF_MASK:  rdata[BTN_COUNT-1:0] = mask;
            default:   rdata = '0;
        endcase
    end

    // Per-button debounce: accept a new level after DEBOUNCE_CYCLES differing samples
    always_comb begin
        btn_db_next = btn_db;
        cnt_next    = cnt;
        for (int unsigned i = 0; i < BTN_COUNT; i++) begin
            if (btn_sync[i] == btn_db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                btn_db_next[i] = btn_sync[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        press = btn_db_next & ~btn_db;
    end

    // Register write decode; a press in the same cycle overrides a W1C
    always_comb begin
        out_next  = gpio_out;
        mask_next = mask;
        evt_next  = evt;
        if (wr_en) begin
            case (offset)
                OFF_OUT:   out_next  = data[OUT_WIDTH-1:0];
                OFF_SET:   out_next  = gpio_out | data[OUT_WIDTH-1:0];
                OFF_CLR:   out_next  = gpio_out & ~data[OUT_WIDTH-1:0];
                OFF_EVENT: evt_next  = evt & ~data[BTN_COUNT-1:0];
                OFF_MASK:  mask_next = data[BTN_COUNT-1:0];
                default:   ;
            endcase
        end
        evt_next = evt_next | press;
        irq_next = |(evt_next & mask_next);
    end

    // State update on the falling edge, aligned with CPU bus writes
    always_ff @(negedge clock) begin
        if (reset) begin
            in_s1    <= '0;
            in_sync  <= '0;
            sw_s1    <= '0;
            sw_sync  <= '0;
            btn_s1   <= '0;
            btn_sync <= '0;
            btn_db   <= '0;
            cnt      <= '0;
            evt      <= '0;
            mask     <= '0;
            gpio_out <= '0;
            irq      <= 1'b0;
        end else begin
            in_s1    <= gpio_in;
            in_sync  <= in_s1;
            sw_s1    <= switch;
            sw_sync  <= sw_s1;
            btn_s1   <= ~button;
            btn_sync <= btn_s1;
            btn_db   <= btn_db_next;
            cnt      <= cnt_next;
            evt      <= evt_next;
            mask     <= mask_next;
            gpio_out <= out_next;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized traffic
// checked against a sample-history reference model.
module tb_gpio_ctrl;

    localparam int DEB = 16;

    logic        clock;
    logic        reset;
    logic [31:0] gpio_in;
    logic [2:0]  button;
    logic [9:0]  switch;
    wire  [63:0] data;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic [31:0] gpio_out;
    logic        irq;

    logic        tb_drive;
    logic [63:0] tb_data;

    int n_tests = 0;
    int n_fail  = 0;

    assign data = tb_drive ? tb_data : 64'bz;

    gpio_ctrl #(
        .BASE_ADDR      (8'h05),
        .IN_WIDTH       (32),
        .OUT_WIDTH      (32),
        .BTN_COUNT      (3),
        .SW_COUNT       (10),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .gpio_in (gpio_in),
        .button  (button),
        .switch  (switch),
        .data    (data),
        .address (address),
        .read    (read),
        .write   (write),
        .gpio_out(gpio_out),
        .irq     (irq)
    );

    // Clock: period 20, falling edges are the active edges
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Reference model: history of raw pin samples, one per falling edge
    logic [44:0] hist [$];
    logic [44:0] old_s;
    logic [31:0] m_out;
    logic [2:0]  m_evt, m_mask, m_db, prev_db;
    logic        m_irq;
    logic [63:0] m_wd;
    int          m_run [3];

    always @(negedge clock) begin
        if (reset) begin
            hist.delete();
            repeat (3) hist.push_back(45'd0);
            m_out  = '0;
            m_evt  = '0;
            m_mask = '0;
            m_db   = '0;
            m_irq  = 1'b0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            hist.push_back({~button, switch, gpio_in});
            if (hist.size() > 3) old_s = hist.pop_front();
            // Debouncer sees the sample taken two edges ago
            old_s   = hist[0];
            prev_db = m_db;
            for (int i = 0; i < 3; i++) begin
                if (old_s[42+i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_wd = data;
            if (write && address[63:56] == 8'h05) begin
                case (address[55:0])
                    56'd1: m_out  = m_wd[31:0];
                    56'd2: m_out  = m_out | m_wd[31:0];
                    56'd3: m_out  = m_out & ~m_wd[31:0];
                    56'd4: m_evt  = m_evt & ~m_wd[2:0];
                    56'd5: m_mask = m_wd[2:0];
                    default: ;
                endcase
            end
            m_evt = m_evt | (m_db & ~prev_db);
            m_irq = |(m_evt & m_mask);
        end
    end

    function automatic logic [63:0] exp_read(input int off);
        logic [44:0] h;
        h = hist[1];
        case (off)
            0:       return {19'd0, m_db, h[41:0]};
            1:       return {32'd0, m_out};
            4:       return {61'd0, m_evt};
            5:       return {61'd0, m_mask};
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] base, input logic [55:0] off, input logic [63:0] val);
        address  = {base, off};
        tb_data  = val;
        tb_drive = 1'b1;
        write    = 1'b1;
        @(posedge clock);
        #1;
        write    = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] base, input logic [55:0] off, output logic [63:0] v);
        address = {base, off};
        read    = 1'b1;
        #1;
        v       = data;
        read    = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        int offs [4] = '{0, 1, 4, 5};
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        foreach (offs[k]) begin
            bus_read(8'h05, 56'(offs[k]), v);
            n_tests++;
            if (v !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_read off=%0d got=%h exp=%h", offs[k], v, 64'd0);
            end
        end
        n_tests++;
        if (gpio_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_gpio_out got=%h exp=%h", gpio_out, 32'd0);
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_out_ops();
        logic [63:0] v;
        bus_write(8'h05, 56'd1, 64'h0000_00F0);
        bus_write(8'h05, 56'd2, 64'h0000_000F);
        bus_write(8'h05, 56'd3, 64'h0000_0030);
        n_tests++;
        if (gpio_out !== 32'h0000_00CF) begin
            n_fail++;
            $display("FAIL out_ops_gpio_out got=%h exp=%h", gpio_out, 32'h0000_00CF);
        end
        bus_read(8'h05, 56'd1, v);
        n_tests++;
        if (v !== 64'h0000_00CF) begin
            n_fail++;
            $display("FAIL out_ops_readback got=%h exp=%h", v, 64'h0000_00CF);
        end
    endtask

    task automatic test_debounce();
        logic [63:0] v, e;
        // Short glitch never reaches the debounced level
        button = 3'b101;
        for (int t = 0; t < 40; t++) begin
            if (t == 10) button = 3'b111;
            tick();
            bus_read(8'h05, 56'd4, v);
            n_tests++;
            if (v !== 64'd0) begin
                n_fail++;
                $display("FAIL glitch_event t=%0d got=%h exp=%h", t, v, 64'd0);
            end
            bus_read(8'h05, 56'd0, v);
            n_tests++;
            if (v[44:42] !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_btn_db t=%0d got=%b exp=000", t, v[44:42]);
            end
        end
        // Held press is accepted on exactly the 2+DEB-th edge
        button = 3'b101;
        for (int t = 1; t <= 2 + DEB; t++) begin
            tick();
            e = (t >= 2 + DEB) ? 64'd2 : 64'd0;
            bus_read(8'h05, 56'd4, v);
            n_tests++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL press_event t=%0d got=%h exp=%h", t, v, e);
            end
        end
        bus_read(8'h05, 56'd0, v);
        n_tests++;
        if (v[43] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_in_bit43 got=%b exp=1", v[43]);
        end
    endtask

    task automatic test_in_latency();
        logic [63:0] v;
        gpio_in = 32'hDEAD_BEEF;
        switch  = 10'h2A5;
        tick();
        bus_read(8'h05, 56'd0, v);
        n_tests++;
        if (v !== 64'h0000_0800_0000_0000) begin
            n_fail++;
            $display("FAIL in_latency_early got=%h exp=%h", v, 64'h0000_0800_0000_0000);
        end
        tick();
        bus_read(8'h05, 56'd0, v);
        n_tests++;
        if (v !== 64'h0000_0AA5_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL in_latency_value got=%h exp=%h", v, 64'h0000_0AA5_DEAD_BEEF);
        end
    endtask

    task automatic test_irq();
        logic [63:0] v;
        bus_write(8'h05, 56'd5, 64'h2);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_on_mask got=%b exp=1", irq);
        end
        bus_write(8'h05, 56'd4, 64'h2);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_off_w1c got=%b exp=0", irq);
        end
        bus_read(8'h05, 56'd4, v);
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL w1c_event got=%h exp=%h", v, 64'd0);
        end
        // Release: no event, debounced level returns to 0
        button = 3'b111;
        repeat (20) tick();
        bus_read(8'h05, 56'd0, v);
        n_tests++;
        if (v !== 64'h0000_02A5_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL release_in got=%h exp=%h", v, 64'h0000_02A5_DEAD_BEEF);
        end
        bus_read(8'h05, 56'd4, v);
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL release_event got=%h exp=%h", v, 64'd0);
        end
        // New press lands on the same edge as a W1C of that bit
        button = 3'b101;
        repeat (1 + DEB) tick();
        bus_write(8'h05, 56'd4, 64'h2);
        bus_read(8'h05, 56'd4, v);
        n_tests++;
        if (v !== 64'd2) begin
            n_fail++;
            $display("FAIL w1c_vs_press got=%h exp=%h", v, 64'd2);
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_vs_press_irq got=%b exp=1", irq);
        end
    endtask

    task automatic test_bad_addr();
        logic [63:0] v;
        // Foreign base: bus must stay undriven so the bench's 0 is what is seen
        tb_data  = 64'd0;
        tb_drive = 1'b1;
        bus_read(8'h04, 56'd1, v);
        tb_drive = 1'b0;
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL foreign_read_drive got=%h exp=%h", v, 64'd0);
        end
        bus_write(8'h04, 56'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(8'h04, 56'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(8'h04, 56'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(8'h05, 56'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(8'h05, 56'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        n_tests++;
        if (gpio_out !== 32'h0000_00CF) begin
            n_fail++;
            $display("FAIL bad_addr_gpio_out got=%h exp=%h", gpio_out, 32'h0000_00CF);
        end
        bus_read(8'h05, 56'd4, v);
        n_tests++;
        if (v !== 64'd2) begin
            n_fail++;
            $display("FAIL bad_addr_event got=%h exp=%h", v, 64'd2);
        end
        bus_read(8'h05, 56'd5, v);
        n_tests++;
        if (v !== 64'd2) begin
            n_fail++;
            $display("FAIL bad_addr_mask got=%h exp=%h", v, 64'd2);
        end
        // Upper write-data bits are dropped
        bus_write(8'h05, 56'd1, 64'hA5A5_A5A5_0000_00CF);
        bus_write(8'h05, 56'd5, 64'hFFFF_FFFF_FFFF_FFFA);
        bus_read(8'h05, 56'd1, v);
        n_tests++;
        if (v !== 64'h0000_00CF) begin
            n_fail++;
            $display("FAIL wide_write_out got=%h exp=%h", v, 64'h0000_00CF);
        end
        bus_read(8'h05, 56'd5, v);
        n_tests++;
        if (v !== 64'd2) begin
            n_fail++;
            $display("FAIL wide_write_mask got=%h exp=%h", v, 64'd2);
        end
        tick();
        for (int off = 2; off <= 7; off += 5) begin
            bus_read(8'h05, 56'(off), v);
            n_tests++;
            if (v !== 64'd0) begin
                n_fail++;
                $display("FAIL zero_read off=%0d got=%h exp=%h", off, v, 64'd0);
            end
        end
        bus_read(8'h05, 56'd3, v);
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL zero_read off=3 got=%h exp=%h", v, 64'd0);
        end
    endtask

    task automatic test_rw_same();
        logic [63:0] v;
        // Simultaneous read+W1C: read shows old EVENT, bus value then clears it
        address = {8'h05, 56'd4};
        read    = 1'b1;
        write   = 1'b1;
        #1;
        v = data;
        n_tests++;
        if (v !== 64'd2) begin
            n_fail++;
            $display("FAIL rw_same_read got=%h exp=%h", v, 64'd2);
        end
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        bus_read(8'h05, 56'd4, v);
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL rw_same_after got=%h exp=%h", v, 64'd0);
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_same_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] v, e;
        button = 3'b100;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_read(8'h05, 56'd0, v);
        n_tests++;
        if (v !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_in got=%h exp=%h", v, 64'd0);
        end
        n_tests++;
        if (gpio_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_gpio_out got=%h exp=%h", gpio_out, 32'd0);
        end
        for (int t = 1; t <= 2 + DEB; t++) begin
            tick();
            bus_read(8'h05, 56'd0, v);
            e = exp_read(0);
            n_tests++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL reset_mid_model t=%0d got=%h exp=%h", t, v, e);
            end
            if (t >= 1 + DEB) begin
                e = (t == 2 + DEB) ? 64'd3 : 64'd0;
                n_tests++;
                if (64'(v[44:42]) !== e) begin
                    n_fail++;
                    $display("FAIL reset_mid_btn t=%0d got=%h exp=%h", t, v[44:42], e);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] v, e, wd;
        logic [7:0]  base;
        int          off, idx, op;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 23) == 0) begin
                idx = $urandom_range(0, 2);
                button[idx] = ~button[idx];
            end
            gpio_in = $urandom;
            switch  = 10'($urandom);
            op = $urandom_range(0, 3);
            if (op < 2) begin
                base = ($urandom_range(0, 7) == 0) ? 8'h04 : 8'h05;
                off  = $urandom_range(0, 7);
                wd   = {$urandom, $urandom};
                bus_write(base, 56'(off), wd);
            end else begin
                tick();
            end
            n_tests++;
            if (gpio_out !== m_out) begin
                n_fail++;
                $display("FAIL rand_gpio_out c=%0d got=%h exp=%h", c, gpio_out, m_out);
            end
            n_tests++;
            if (irq !== m_irq) begin
                n_fail++;
                $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, m_irq);
            end
            off = $urandom_range(0, 7);
            bus_read(8'h05, 56'(off), v);
            e = exp_read(off);
            n_tests++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL rand_read c=%0d off=%0d got=%h exp=%h", c, off, v, e);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        button   = 3'b111;
        gpio_in  = '0;
        switch   = '0;
        address  = '0;
        read     = 1'b0;
        write    = 1'b0;
        tb_drive = 1'b0;
        tb_data  = '0;

        test_reset();
        test_out_ops();
        test_debounce();
        test_in_latency();
        test_irq();
        test_bad_addr();
        test_rw_same();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
